ebi_master: RTL and testbench

- Synthesizable initiator for the EBI multiplexed address/data bus that the display driver responds to.
- Converts single-beat read/write requests, given as valid/ready, into ALE/WE/RE strobe sequences on a 16-bit shared AD bus, and drives bank_select.
- Used by the on-FPGA loader and self-test paths to fill OAM, sprite, palette and tile RAM without the MCU.
- Bidirectional AD is split into out/oe/in; the tri-state buffer lives at the top level.

---
 rtl/ebi_master.sv | 158 +++++++++++++++
 tb/tb_ebi_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebi_master.sv
// ebi_master: single-beat initiator for the multiplexed 16-bit EBI address/data
// bus used by the display driver.
//
// A request accepted on req_valid && req_ready is played out as an address
// phase (ALE low), one ALE-high cycle, a strobe phase (WE or RE low) and a
// hold phase, then the master returns to IDLE for at least one cycle.
//
// Ports:
//   clk_100m, rst              clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we, req_bank,          request fields, captured at accept
//   req_addr, req_wdata
//   rsp_valid, rsp_rdata       one-cycle read response pulse and data
//   busy                       transaction in progress
//   ebi_ad_out/oe/in           split AD bus; tri-state buffer is external
//   EBI_ALE, EBI_WE, EBI_RE    active-low bus strobes
//   bank_select                bank of the current/last transaction
module ebi_master #(
  parameter int ADDR_CYC = 2,
  parameter int STRB_CYC = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_bank,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [15:0] ebi_ad_out,
  output logic        ebi_ad_oe,
  input  logic [15:0] ebi_ad_in,
  output logic        EBI_ALE,
  output logic        EBI_WE,
  output logic        EBI_RE,
  output logic [2:0]  bank_select
);

  // Phase counters are loaded with length-1 and count down to zero.
  localparam logic [3:0] ADDR_LD = 4'(ADDR_CYC - 1);
  localparam logic [3:0] STRB_LD = 4'(STRB_CYC - 1);
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_ALEH = 3'd2,
    ST_STRB = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [15:0] wdata_r;
  logic        accept_s;

  // req_ready is only ever high in IDLE, so this is the IDLE accept condition.
  assign accept_s = req_valid && req_ready;

  // Transaction sequencer; every bus-facing output is a register of this block.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      wdata_r     <= 16'h0000;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'h0000;
      busy        <= 1'b0;
      ebi_ad_out  <= 16'h0000;
      ebi_ad_oe   <= 1'b0;
      EBI_ALE     <= 1'b1;
      EBI_WE      <= 1'b1;
      EBI_RE      <= 1'b1;
      bank_select <= 3'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_ADDR;
            cnt_r       <= ADDR_LD;
            we_r        <= req_we;
            wdata_r     <= req_wdata;
            bank_select <= req_bank;
            ebi_ad_out  <= req_addr;
            ebi_ad_oe   <= 1'b1;
            EBI_ALE     <= 1'b0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (cnt_r == 4'd0) begin
            // Address stays driven through the ALE rising edge.
            state_r <= ST_ALEH;
            EBI_ALE <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ALEH: begin
          state_r <= ST_STRB;
          cnt_r   <= STRB_LD;
          if (we_r) begin
            ebi_ad_out <= wdata_r;
            EBI_WE     <= 1'b0;
          end else begin
            // Release the bus on the same edge RE falls so the responder
            // never sees contention.
            ebi_ad_oe <= 1'b0;
            EBI_RE    <= 1'b0;
          end
        end
        ST_STRB: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_HOLD;
            cnt_r   <= HOLD_LD;
            EBI_WE  <= 1'b1;
            EBI_RE  <= 1'b1;
            if (!we_r) begin
              rsp_rdata <= ebi_ad_in;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_r == 4'd0) begin
            state_r   <= ST_IDLE;
            ebi_ad_oe <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= ~we_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          ebi_ad_oe <= 1'b0;
          EBI_ALE   <= 1'b1;
          EBI_WE    <= 1'b1;
          EBI_RE    <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_master.sv
// tb_ebi_master: randomized scoreboard bench for ebi_master.
// At each accept the expected per-cycle bus picture of the whole transaction
// (derived from the phase lengths) is queued; a negedge monitor pops one entry
// per cycle and compares. A responder model answers reads from its own memory,
// while the reference memory is updated at accept time.
module tb_ebi_master;

  localparam int A   = 2;
  localparam int S   = 3;
  localparam int H   = 1;
  localparam int LEN = A + 1 + S + H;

  logic        clk_100m = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_bank = 3'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic [15:0] ebi_ad_in = 16'h0000;
  logic        req_ready, rsp_valid, busy, ebi_ad_oe, EBI_ALE, EBI_WE, EBI_RE;
  logic [15:0] rsp_rdata, ebi_ad_out;
  logic [2:0]  bank_select;

  // Second instance with minimum phase lengths.
  logic        r2_valid = 1'b0;
  logic        r2_we = 1'b0;
  logic [2:0]  r2_bank = 3'd0;
  logic [15:0] r2_addr = 16'h0000;
  logic [15:0] r2_wdata = 16'h0000;
  logic [15:0] r2_ad_in;
  logic        r2_ready, r2_rsp_valid, r2_busy, r2_oe, r2_ale, r2_we_n, r2_re_n;
  logic [15:0] r2_rdata, r2_ad_out;
  logic [2:0]  r2_bank_sel;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic        ale;
    logic        we;
    logic        re;
    logic        oe;
    logic [15:0] ad;
    logic        chk_ad;
    logic [2:0]  bank;
    logic        rv;
    logic [15:0] rd;
    logic        rdy;
    logic        bsy;
  } snap_t;

  snap_t       exp_q[$];
  int          acc_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] resp_mem[int];

  ebi_master #(.ADDR_CYC(A), .STRB_CYC(S), .HOLD_CYC(H)) dut (
    .clk_100m(clk_100m), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .ebi_ad_out(ebi_ad_out), .ebi_ad_oe(ebi_ad_oe), .ebi_ad_in(ebi_ad_in),
    .EBI_ALE(EBI_ALE), .EBI_WE(EBI_WE), .EBI_RE(EBI_RE), .bank_select(bank_select)
  );

  ebi_master #(.ADDR_CYC(1), .STRB_CYC(1), .HOLD_CYC(1)) dut_min (
    .clk_100m(clk_100m), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_we(r2_we), .req_bank(r2_bank), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata), .busy(r2_busy),
    .ebi_ad_out(r2_ad_out), .ebi_ad_oe(r2_oe), .ebi_ad_in(r2_ad_in),
    .EBI_ALE(r2_ale), .EBI_WE(r2_we_n), .EBI_RE(r2_re_n), .bank_select(r2_bank_sel)
  );

  assign r2_ad_in = r2_re_n ? 16'h0000 : 16'hC3C3;

  initial forever #5 clk_100m = ~clk_100m;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Value returned by the responder for a location never written.
  function automatic logic [15:0] dflt(input int key);
    return key[15:0] ^ 16'h5A5A ^ {key[18:16], 13'h0000};
  endfunction

  // Accept detector: builds the expected cycle-by-cycle picture of the transaction.
  always @(posedge clk_100m) begin
    cyc++;
    if (!rst && req_valid && req_ready) begin
      int    key;
      snap_t s;
      key = {13'd0, req_bank, req_addr};
      acc_q.push_back(cyc);
      for (int k = 0; k < LEN; k++) begin
        s = '{ale: 1'b1, we: 1'b1, re: 1'b1, oe: 1'b0, ad: 16'h0000, chk_ad: 1'b0,
              bank: req_bank, rv: 1'b0, rd: 16'h0000, rdy: 1'b0, bsy: 1'b1};
        if (k < A) begin
          s.ale = 1'b0; s.oe = 1'b1; s.ad = req_addr; s.chk_ad = 1'b1;
        end else if (k == A) begin
          s.oe = 1'b1; s.ad = req_addr; s.chk_ad = 1'b1;
        end else if (k < A + 1 + S) begin
          if (req_we) begin
            s.we = 1'b0; s.oe = 1'b1; s.ad = req_wdata; s.chk_ad = 1'b1;
          end else begin
            s.re = 1'b0;
          end
        end else if (req_we) begin
          s.oe = 1'b1; s.ad = req_wdata; s.chk_ad = 1'b1;
        end
        exp_q.push_back(s);
      end
      s = '{ale: 1'b1, we: 1'b1, re: 1'b1, oe: 1'b0, ad: 16'h0000, chk_ad: 1'b0,
            bank: req_bank, rv: ~req_we, rd: 16'h0000, rdy: 1'b1, bsy: 1'b0};
      if (req_we) ref_mem[key] = req_wdata;
      else s.rd = ref_mem.exists(key) ? ref_mem[key] : dflt(key);
      exp_q.push_back(s);
    end
  end

  // Responder: latches address on ALE rise, stores on WE rise, drives AD while RE low.
  logic        ale_p = 1'b1;
  logic        we_p = 1'b1;
  logic [15:0] wd_l = 16'h0000;
  int          lat_key = 0;
  always @(negedge clk_100m) begin
    if (rst) begin
      ale_p = 1'b1; we_p = 1'b1;
      ebi_ad_in = 16'($urandom);
    end else begin
      if (!ale_p && EBI_ALE) lat_key = {13'd0, bank_select, ebi_ad_out};
      if (!EBI_WE) wd_l = ebi_ad_out;
      if (!we_p && EBI_WE) resp_mem[lat_key] = wd_l;
      if (!EBI_RE) ebi_ad_in = resp_mem.exists(lat_key) ? resp_mem[lat_key] : dflt(lat_key);
      else ebi_ad_in = 16'($urandom);
      ale_p = EBI_ALE; we_p = EBI_WE;
    end
  end

  // Monitor: compares each cycle against the queued picture (or idle when empty).
  snap_t      m_act, m_exp;
  logic [2:0] last_bank = 3'd0;
  always @(negedge clk_100m) begin
    if (rst) begin
      exp_q.delete();
      last_bank = 3'd0;
      chk("reset_values",
          64'({EBI_ALE, EBI_WE, EBI_RE, ebi_ad_oe, ebi_ad_out, bank_select,
               rsp_valid, rsp_rdata, req_ready, busy}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0}));
    end else begin
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
      end else begin
        m_exp = '{ale: 1'b1, we: 1'b1, re: 1'b1, oe: 1'b0, ad: 16'h0000, chk_ad: 1'b0,
                  bank: last_bank, rv: 1'b0, rd: 16'h0000, rdy: 1'b1, bsy: 1'b0};
      end
      last_bank = m_exp.bank;
      m_act = '{ale: EBI_ALE, we: EBI_WE, re: EBI_RE, oe: ebi_ad_oe, ad: ebi_ad_out,
                chk_ad: m_exp.chk_ad, bank: bank_select, rv: rsp_valid, rd: rsp_rdata,
                rdy: req_ready, bsy: busy};
      if (!m_exp.chk_ad) m_act.ad = m_exp.ad;
      if (!m_exp.rv) m_act.rd = m_exp.rd;
      chk("bus_cycle", 64'(m_act), 64'(m_exp));
      chk("we_re_exclusive", 64'(!EBI_WE && !EBI_RE), 64'(0));
      chk("ale_vs_strobe", 64'(!EBI_ALE && (!EBI_WE || !EBI_RE)), 64'(0));
      chk("oe_during_re", 64'(ebi_ad_oe && !EBI_RE), 64'(0));
    end
  end

  // Issue one request from a negedge; returns at the negedge after accept.
  task automatic issue(input logic w, input logic [2:0] b, input logic [15:0] a,
                       input logic [15:0] d, input bit hold);
    int n = 0;
    req_valid = 1'b1; req_we = w; req_bank = b; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk_100m);
      n++;
    end
    chk("accept_wait", 64'(n < 100), 64'(1));
    @(posedge clk_100m);
    @(negedge clk_100m);
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      req_bank  = 3'($urandom);
      req_we    = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || !req_ready) && n < 50) begin
      @(negedge clk_100m);
      n++;
    end
    chk("drain", 64'(n < 50), 64'(1));
  endtask

  initial begin
    int n, wl, na;
    repeat (3) @(negedge clk_100m);
    rst = 1'b0;
    @(negedge clk_100m);

    // Directed write, then write/read of BEEF.
    issue(1'b1, 3'd2, 16'h0123, 16'hA5A5, 1'b0);
    drain();
    issue(1'b1, 3'd0, 16'h0040, 16'hBEEF, 1'b0);
    issue(1'b0, 3'd0, 16'h0040, 16'h0000, 1'b0);
    drain();

    // Three back-to-back writes with valid held high.
    na = acc_q.size();
    issue(1'b1, 3'd1, 16'h0200, 16'h1111, 1'b1);
    issue(1'b1, 3'd3, 16'h0201, 16'h2222, 1'b1);
    issue(1'b1, 3'd6, 16'h0202, 16'h3333, 1'b0);
    drain();
    chk("b2b_gap1", 64'(acc_q[na + 1] - acc_q[na]), 64'(LEN + 1));
    chk("b2b_gap2", 64'(acc_q[na + 2] - acc_q[na + 1]), 64'(LEN + 1));
    chk("b2b_last_bank", 64'(bank_select), 64'(6));

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            {13'd0, 3'($urandom_range(0, 7))}, 16'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk_100m);
    end
    req_valid = 1'b0;
    drain();

    // Reset during the second WE-low cycle.
    issue(1'b1, 3'd7, 16'hF000, 16'h0F0F, 1'b0);
    repeat (4) @(posedge clk_100m);
    #2;
    chk("we_low_before_abort", 64'(EBI_WE), 64'(0));
    rst = 1'b1;
    #1;
    chk("abort_async", 64'({EBI_ALE, EBI_WE, EBI_RE, ebi_ad_oe, bank_select}),
        64'({1'b1, 1'b1, 1'b1, 1'b0, 3'd0}));
    @(negedge clk_100m);
    @(negedge clk_100m);
    rst = 1'b0;
    repeat (3) @(negedge clk_100m);
    issue(1'b1, 3'd1, 16'h0005, 16'h7E7E, 1'b0);
    issue(1'b0, 3'd1, 16'h0005, 16'h0000, 1'b0);
    drain();

    // Minimum phase lengths: 4-cycle write, single RE-low read capture.
    r2_valid = 1'b1; r2_we = 1'b1; r2_bank = 3'd5; r2_addr = 16'h0055; r2_wdata = 16'h1234;
    @(posedge clk_100m);
    #1;
    r2_valid = 1'b0;
    n = 0; wl = 0;
    while (!r2_ready && n < 20) begin
      @(posedge clk_100m);
      #1;
      n++;
      if (!r2_we_n) begin
        wl++;
        chk("min_wdata", 64'(r2_ad_out), 64'(16'h1234));
      end
    end
    chk("min_write_len", 64'(n), 64'(4));
    chk("min_we_cycles", 64'(wl), 64'(1));
    @(negedge clk_100m);
    r2_valid = 1'b1; r2_we = 1'b0; r2_addr = 16'h0066;
    @(posedge clk_100m);
    #1;
    r2_valid = 1'b0;
    n = 0;
    while (!r2_rsp_valid && n < 20) begin
      @(posedge clk_100m);
      #1;
      n++;
    end
    chk("min_read_len", 64'(n), 64'(4));
    chk("min_rdata", 64'(r2_rdata), 64'(16'hC3C3));
    @(posedge clk_100m);
    #1;
    chk("min_rsp_pulse", 64'(r2_rsp_valid), 64'(0));

    repeat (2) @(negedge clk_100m);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
